// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the DE2 16x2 HD44780 LCD read and write engines.
// Holds the read FSM state encoding, default bus timing (in 50 MHz clock cycles)
// and the command bytes used by the write sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_EN_LO = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_t;

    // Default read-cycle timing at 50 MHz
    localparam int T_SETUP_DEF   = 3;     // tAS >= 40 ns
    localparam int T_EN_HIGH_DEF = 25;    // PWEH >= 450 ns
    localparam int T_SAMPLE_DEF  = 10;    // after tDDR <= 160 ns
    localparam int T_EN_LOW_DEF  = 30;    // tH plus full cycle >= 1 us
    localparam int MAX_POLLS_DEF = 4096;

    // Command bytes shared with the write controller
    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_LINE1      = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2      = 8'hC0;  // DDRAM address 0x40

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable 8-bit down-counter shared by every bus phase.
// Loading value N-1 on phase entry makes tc rise in the N-th cycle of the phase.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       tc
);

    // Reload on phase entry, otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign tc = (count == 8'd0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle engine (busy flag / address counter and DDRAM data reads).
// Optional feature macro LCD_READ_TIMEOUT_EN bounds busy-flag polling to MAX_POLLS
// re-reads and reports a give-up through oTimeout; without it polling is unbounded.
// LCD_DATA is never driven here; the top level muxes LCD_RW/EN/RS using oActive.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = T_SETUP_DEF,
    parameter int T_EN_HIGH = T_EN_HIGH_DEF,
    parameter int T_SAMPLE  = T_SAMPLE_DEF,
    parameter int T_EN_LOW  = T_EN_LOW_DEF
`ifdef LCD_READ_TIMEOUT_EN
    ,
    parameter int MAX_POLLS = MAX_POLLS_DEF
`endif
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic [7:0] oDATA,
    output logic       oBusy,
    output logic [6:0] oAddr,
    output logic       oDone,
    output logic       oActive,
    output logic       oTimeout,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    // Down-counter value at which EN has been high for T_SAMPLE cycles
    localparam logic [7:0] SAMPLE_CNT = 8'(T_EN_HIGH - 1 - T_SAMPLE);

    lcd_state_t state;
    logic       rs_q;
    logic       poll_q;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic [7:0] tmr_cnt;
    logic       tmr_tc;
    logic       poll_active;
    logic       repeat_read;

    assign LCD_DATA = 8'hzz;

    lcd_phase_timer u_timer (
        .clk      (iCLK),
        .rst      (iRST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .tc       (tmr_tc)
    );

    // Busy flag from the read that just finished keeps a poll going
    assign poll_active = poll_q && oBusy;

`ifdef LCD_READ_TIMEOUT_EN
    logic [12:0] poll_cnt;
    logic        limit_hit;

    assign limit_hit   = (poll_cnt == 13'(MAX_POLLS));
    assign repeat_read = poll_active && !limit_hit;

    // Count poll re-reads; flag the transaction that gives up while BF is still set
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            poll_cnt <= 13'd0;
            oTimeout <= 1'b0;
        end else if (state == ST_IDLE && iStart) begin
            poll_cnt <= 13'd0;
            oTimeout <= 1'b0;
        end else if (state == ST_EN_LO && tmr_tc && poll_active) begin
            if (limit_hit) begin
                oTimeout <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 13'd1;
            end
        end
    end
`else
    assign repeat_read = poll_active;
    assign oTimeout    = 1'b0;
`endif

    // Reload the phase timer on every entry into a timed phase
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        case (state)
            ST_IDLE: if (iStart) begin
                tmr_load = 1'b1;
                tmr_val  = 8'(T_SETUP - 1);
            end
            ST_SETUP: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = 8'(T_EN_HIGH - 1);
            end
            ST_EN_HI: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = 8'(T_EN_LOW - 1);
            end
            ST_EN_LO: if (tmr_tc && repeat_read) begin
                tmr_load = 1'b1;
                tmr_val  = 8'(T_SETUP - 1);
            end
            default: ;
        endcase
    end

    // Read-cycle sequencer with registered bus strobes and captured results
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= ST_IDLE;
            rs_q    <= 1'b0;
            poll_q  <= 1'b0;
            oDATA   <= 8'd0;
            oBusy   <= 1'b0;
            oAddr   <= 7'd0;
            oDone   <= 1'b0;
            oActive <= 1'b0;
            LCD_RW  <= 1'b0;
            LCD_EN  <= 1'b0;
            LCD_RS  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: if (iStart) begin
                    state   <= ST_SETUP;
                    rs_q    <= iRS;
                    poll_q  <= iPoll && !iRS;
                    LCD_RW  <= 1'b1;
                    LCD_RS  <= iRS;
                    oActive <= 1'b1;
                end
                ST_SETUP: if (tmr_tc) begin
                    state  <= ST_EN_HI;
                    LCD_EN <= 1'b1;
                end
                ST_EN_HI: begin
                    if (tmr_cnt == SAMPLE_CNT) begin
                        oDATA <= LCD_DATA;
                        if (!rs_q) begin
                            oBusy <= LCD_DATA[7];
                            oAddr <= LCD_DATA[6:0];
                        end
                    end
                    if (tmr_tc) begin
                        state  <= ST_EN_LO;
                        LCD_EN <= 1'b0;
                    end
                end
                ST_EN_LO: if (tmr_tc) begin
                    if (repeat_read) begin
                        state <= ST_SETUP;
                    end else begin
                        state   <= ST_DONE;
                        oDone   <= 1'b1;
                        LCD_RW  <= 1'b0;
                        LCD_RS  <= 1'b0;
                        oActive <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed bench for lcd_reader with a bus model that drives
// LCD_DATA while LCD_EN is high. Cycle counts include the iStart cycle as cycle 1.
`timescale 1ns/1ps
module tb_lcd_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rs;
  logic       poll;
  logic [7:0] data;
  logic       busy;
  logic [6:0] addr;
  logic       done;
  logic       active;
  logic       timeout;
  wire  [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_rs;
  logic [7:0] bus_val;

  int total = 0;
  int bad   = 0;

  // Results of the last run_txn call
  int   first_done;
  int   dones;
  int   pulses;
  int   en_len;
  logic rw_bad;
  logic rs_bad;

  always #10 clk = ~clk;

  // LCD model: drives the bus only while the controller strobes EN
  assign lcd_data = lcd_en ? bus_val : 8'hzz;

`ifdef LCD_READ_TIMEOUT_EN
  lcd_reader #(.MAX_POLLS(5)) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iStart   (start),
    .iRS      (rs),
    .iPoll    (poll),
    .oDATA    (data),
    .oBusy    (busy),
    .oAddr    (addr),
    .oDone    (done),
    .oActive  (active),
    .oTimeout (timeout),
    .LCD_DATA (lcd_data),
    .LCD_RW   (lcd_rw),
    .LCD_EN   (lcd_en),
    .LCD_RS   (lcd_rs)
  );
`else
  lcd_reader dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iStart   (start),
    .iRS      (rs),
    .iPoll    (poll),
    .oDATA    (data),
    .oBusy    (busy),
    .oAddr    (addr),
    .oDone    (done),
    .oActive  (active),
    .oTimeout (timeout),
    .LCD_DATA (lcd_data),
    .LCD_RW   (lcd_rw),
    .LCD_EN   (lcd_en),
    .LCD_RS   (lcd_rs)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction for run_len cycles; reads 1..busy_n return busy_v, later ones final_v.
  // Extra iStart pulses are driven in cycles s2 and s3 (0 = none).
  task automatic run_txn(input logic r, input logic p, input int busy_n,
                         input logic [7:0] busy_v, input logic [7:0] final_v,
                         input int s2, input int s3, input int run_len);
    int   n;
    int   cur_len;
    logic prev_en;
    first_done = 0;
    dones      = 0;
    pulses     = 0;
    en_len     = 0;
    rw_bad     = 1'b0;
    rs_bad     = 1'b0;
    cur_len    = 0;
    @(negedge clk);
    rs      = r;
    poll    = p;
    start   = 1'b1;
    bus_val = (busy_n > 0) ? busy_v : final_v;
    n       = 1;
    prev_en = lcd_en;
    while (n < run_len) begin
      @(negedge clk);
      n++;
      start = (n == s2) || (n == s3);
      if (done) begin
        dones++;
        if (first_done == 0) first_done = n;
      end
      if (first_done == 0) begin
        if (lcd_rw !== 1'b1) rw_bad = 1'b1;
        if (lcd_rs !== r) rs_bad = 1'b1;
      end
      if (lcd_en && !prev_en) begin
        pulses++;
        bus_val = (pulses <= busy_n) ? busy_v : final_v;
      end
      if (lcd_en) cur_len++;
      if (!lcd_en && prev_en) begin
        en_len  = cur_len;
        cur_len = 0;
      end
      prev_en = lcd_en;
    end
    start = 1'b0;
  endtask

  initial begin
    int   k;
    logic saw_done;
    rst     = 1'b1;
    start   = 1'b0;
    rs      = 1'b0;
    poll    = 1'b0;
    bus_val = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_en",      32'(lcd_en),  32'h0);
    check("rst_rw",      32'(lcd_rw),  32'h0);
    check("rst_rs",      32'(lcd_rs),  32'h0);
    check("rst_active",  32'(active),  32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_data",    32'(data),    32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    rst = 1'b0;

    // Single busy/address read
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'h45, 0, 0, 70);
    check("rd0_latency", 32'(first_done), 32'd60);
    check("rd0_dones",   32'(dones),      32'd1);
    check("rd0_pulses",  32'(pulses),     32'd1);
    check("rd0_en_len",  32'(en_len),     32'd25);
    check("rd0_rw_held", 32'(rw_bad),     32'd0);
    check("rd0_data",    32'(data),       32'h45);
    check("rd0_busy",    32'(busy),       32'h0);
    check("rd0_addr",    32'(addr),       32'h45);
    check("rd0_idle_rw", 32'(lcd_rw),     32'h0);
    check("rd0_idle_act",32'(active),     32'h0);

    // DDRAM data read leaves BF/AC untouched
    run_txn(1'b1, 1'b1, 0, 8'h00, 8'h41, 0, 0, 70);
    check("rd1_latency", 32'(first_done), 32'd60);
    check("rd1_rs_held", 32'(rs_bad),     32'd0);
    check("rd1_data",    32'(data),       32'h41);
    check("rd1_busy",    32'(busy),       32'h0);
    check("rd1_addr",    32'(addr),       32'h45);

    // Poll: three busy reads then ready at address 0x10
    run_txn(1'b0, 1'b1, 3, 8'h80, 8'h10, 0, 0, 250);
    check("poll_latency", 32'(first_done), 32'd234);
    check("poll_pulses",  32'(pulses),     32'd4);
    check("poll_dones",   32'(dones),      32'd1);
    check("poll_busy",    32'(busy),       32'h0);
    check("poll_addr",    32'(addr),       32'h10);
    check("poll_data",    32'(data),       32'h10);

    // iStart during SETUP and during DONE is ignored
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'h22, 3, 60, 130);
    check("ign_latency", 32'(first_done), 32'd60);
    check("ign_dones",   32'(dones),      32'd1);
    check("ign_pulses",  32'(pulses),     32'd1);
    check("ign_data",    32'(data),       32'h22);

    // Reset in the middle of EN-high, after the sample point
    @(negedge clk);
    bus_val = 8'h33;
    rs      = 1'b0;
    poll    = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!lcd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_en_seen", 32'(lcd_en), 32'h1);
    repeat (15) @(negedge clk);
    check("abort_pre_data", 32'(data),   32'h33);
    check("abort_pre_en",   32'(lcd_en), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_en",     32'(lcd_en), 32'h0);
    check("abort_rw",     32'(lcd_rw), 32'h0);
    check("abort_active", 32'(active), 32'h0);
    check("abort_data",   32'(data),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'h0);

`ifdef LCD_READ_TIMEOUT_EN
    // Poll limit of 5 re-reads against a permanently busy LCD
    run_txn(1'b0, 1'b1, 100, 8'hFF, 8'hFF, 0, 0, 360);
    check("to_pulses",  32'(pulses),     32'd6);
    check("to_latency", 32'(first_done), 32'd350);
    check("to_dones",   32'(dones),      32'd1);
    check("to_flag",    32'(timeout),    32'h1);
    @(negedge clk);
    bus_val = 8'h00;
    rs      = 1'b0;
    poll    = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to_clear", 32'(timeout), 32'h0);
    repeat (70) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
